// File: rtl/mmio_uart_hub_if.sv
// mmio_uart_hub_if: CPU data-port bundle between the EX/MEM stage and the MMIO hub
interface mmio_uart_hub_if;
  logic [31:0] addr;
  logic rd;
  logic wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic hit;
  modport master (output addr, rd, wr, wdata, input rdata, hit);
  modport slave (input addr, rd, wr, wdata, output rdata, hit);
endinterface

// File: rtl/mmio_uart_hub.sv
// mmio_uart_hub: MMIO hub with TX/RX FIFOs, status/ctrl registers, irq and LED register
module mmio_uart_hub #(
  parameter logic [31:0] BASE_UART = 32'h1000_0000,
  parameter logic [31:0] BASE_LED = 32'h2000_0000,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int LED_W = 16
) (
  input logic clk,
  input logic rst,
  mmio_uart_hub_if.slave bus,
  output logic [7:0] uart_tx_data,
  output logic uart_tx_we,
  input logic uart_tx_busy,
  input logic [7:0] uart_rx_data,
  input logic uart_rx_valid,
  output logic uart_rx_re,
  output logic [LED_W-1:0] led_out,
  output logic irq
);
  localparam int TA = $clog2(TX_DEPTH);
  localparam int RA = $clog2(RX_DEPTH);
  typedef enum logic [1:0] {T_IDLE, T_HOLD, T_WAIT} t_state_t;
  typedef enum logic {R_IDLE, R_GAP} r_state_t;
  t_state_t t_state;
  r_state_t r_state;
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];
  logic [TA-1:0] tx_rp, tx_wp;
  logic [RA-1:0] rx_rp, rx_wp;
  logic [TA:0] tx_cnt;
  logic [RA:0] rx_cnt;
  logic rx_ovr, tx_ovf, rx_ie, tx_ie;
  logic sel_data, sel_stat, sel_ctrl, sel_led;
  logic rx_nempty, tx_full, tx_idle, tx_push, tx_pop, rx_push, rx_pop, stat_wr;
  logic [31:0] stat;
  assign sel_data = bus.addr == BASE_UART;
  assign sel_stat = bus.addr == BASE_UART + 32'h4;
  assign sel_ctrl = bus.addr == BASE_UART + 32'h8;
  assign sel_led = bus.addr == BASE_LED;
  assign bus.hit = sel_data | sel_stat | sel_ctrl | sel_led;
  assign stat_wr = bus.wr & sel_stat;
  assign rx_nempty = rx_cnt != '0;
  assign tx_full = tx_cnt == (TA+1)'(TX_DEPTH);
  assign tx_idle = tx_cnt == '0 && t_state == T_IDLE;
  // Strobes are gated by rst so nothing reaches the UART core while reset is held
  assign uart_tx_we = rst && t_state == T_IDLE && tx_cnt != '0 && !uart_tx_busy;
  assign uart_tx_data = uart_tx_we ? tx_mem[tx_rp] : 8'h0;
  assign uart_rx_re = rst && r_state == R_IDLE && uart_rx_valid;
  assign tx_pop = uart_tx_we;
  assign tx_push = bus.wr & sel_data & (!tx_full | tx_pop);
  assign rx_pop = bus.rd & sel_data & rx_nempty;
  assign rx_push = uart_rx_re & (rx_cnt != (RA+1)'(RX_DEPTH) | rx_pop);
  assign stat = {8'h0, 8'(tx_cnt), 8'(rx_cnt), 3'b0, tx_ovf, rx_ovr, tx_idle, tx_full, rx_nempty};
  assign bus.rdata = sel_data ? {24'h0, rx_nempty ? rx_mem[rx_rp] : 8'h0} :
                     sel_stat ? stat :
                     sel_ctrl ? {30'h0, tx_ie, rx_ie} :
                     sel_led ? 32'(led_out) : 32'h0;
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.wdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= uart_rx_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_state <= T_IDLE;
      r_state <= R_IDLE;
      tx_rp <= '0;
      tx_wp <= '0;
      rx_rp <= '0;
      rx_wp <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      rx_ovr <= 1'b0;
      tx_ovf <= 1'b0;
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
      led_out <= '0;
      irq <= 1'b0;
    end else begin
      tx_wp <= tx_wp + TA'(tx_push);
      tx_rp <= tx_rp + TA'(tx_pop);
      tx_cnt <= tx_cnt + (TA+1)'(tx_push) - (TA+1)'(tx_pop);
      rx_wp <= rx_wp + RA'(rx_push);
      rx_rp <= rx_rp + RA'(rx_pop);
      rx_cnt <= rx_cnt + (RA+1)'(rx_push) - (RA+1)'(rx_pop);
      // HOLD covers the cycle before busy rises; WAIT then tracks busy
      t_state <= t_state == T_IDLE ? (uart_tx_we ? T_HOLD : T_IDLE) :
                 t_state == T_HOLD ? T_WAIT : (uart_tx_busy ? T_WAIT : T_IDLE);
      r_state <= r_state == R_IDLE && uart_rx_valid ? R_GAP : R_IDLE;
      rx_ovr <= (uart_rx_re & !rx_push) | (rx_ovr & !(stat_wr & bus.wdata[3]));
      tx_ovf <= (bus.wr & sel_data & !tx_push) | (tx_ovf & !(stat_wr & bus.wdata[4]));
      if (bus.wr & sel_ctrl) {tx_ie, rx_ie} <= bus.wdata[1:0];
      if (bus.wr & sel_led) led_out <= bus.wdata[LED_W-1:0];
      irq <= (rx_ie & rx_nempty) | (tx_ie & tx_idle);
    end
  end
endmodule

// File: tb/tb_mmio_uart_hub.sv
// tb_mmio_uart_hub: table-driven register checks plus TX/RX scoreboard sequences
module tb_mmio_uart_hub;
  localparam logic [31:0] DATA = 32'h1000_0000, STAT = 32'h1000_0004, CTRL = 32'h1000_0008, LED = 32'h2000_0000;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  mmio_uart_hub_if bus();
  logic [7:0] uart_tx_data, uart_rx_data = 8'h0;
  logic uart_tx_we, uart_tx_busy, uart_rx_valid = 1'b0, uart_rx_re, irq;
  logic [15:0] led_out;
  logic hold_busy = 1'b0, re_prev = 1'b0, re_b2b = 1'b0;
  int busy_cnt = 0, cyc = 0, re_cnt = 0, checks = 0, errors = 0;
  logic [7:0] exp_q[$], obs_q[$], rx_src[$];
  int obs_cyc[$];
  typedef struct {
    logic [31:0] addr;
    logic rd;
    logic wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic hit;
  } vec_t;
  vec_t tbl[14];

  mmio_uart_hub #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .uart_tx_data(uart_tx_data), .uart_tx_we(uart_tx_we), .uart_tx_busy(uart_tx_busy),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_re(uart_rx_re),
    .led_out(led_out), .irq(irq)
  );

  // UART core models: busy for 10 cycles after each strobe, one RX byte at a time
  assign uart_tx_busy = hold_busy || busy_cnt != 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    busy_cnt <= uart_tx_we ? 10 : (busy_cnt > 0 ? busy_cnt - 1 : 0);
    if (uart_rx_re) uart_rx_valid <= 1'b0;
    else if (!uart_rx_valid && rx_src.size() > 0) begin
      uart_rx_data <= rx_src.pop_front();
      uart_rx_valid <= 1'b1;
    end
  end
  always @(negedge clk) begin
    if (uart_tx_we) begin
      obs_q.push_back(uart_tx_data);
      obs_cyc.push_back(cyc);
    end
    if (uart_rx_re) re_cnt <= re_cnt + 1;
    if (uart_rx_re && re_prev) re_b2b <= 1'b1;
    re_prev <= uart_rx_re;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic access(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d);
    bus.addr = a;
    bus.rd = r;
    bus.wr = w;
    bus.wdata = d;
    tick();
    bus.rd = 1'b0;
    bus.wr = 1'b0;
  endtask
  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    bus.rd = 1'b1;
    #1;
    check(name, bus.rdata, exp);
    tick();
    bus.rd = 1'b0;
  endtask
  task automatic wait_obs(input int n, input int lim);
    for (int k = 0; k < lim && obs_q.size() < n; k++) tick();
    check("tx_wait", obs_q.size(), n);
  endtask
  task automatic cmp_tx(input string name);
    while (obs_q.size() > 0 && exp_q.size() > 0) check(name, obs_q.pop_front(), exp_q.pop_front());
  endtask

  initial begin
    int wcyc, base, cr;
    tbl[0] = '{STAT, 1'b1, 1'b0, 32'h0, 32'h4, 1'b1};
    tbl[1] = '{CTRL, 1'b0, 1'b1, 32'h3, 32'h0, 1'b1};
    tbl[2] = '{CTRL, 1'b1, 1'b0, 32'h0, 32'h3, 1'b1};
    tbl[3] = '{CTRL, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h3, 1'b1};
    tbl[4] = '{CTRL, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[5] = '{LED, 1'b0, 1'b1, 32'hFFFF_A5A5, 32'h0, 1'b1};
    tbl[6] = '{LED, 1'b1, 1'b0, 32'h0, 32'h0000_A5A5, 1'b1};
    tbl[7] = '{32'h2000_0004, 1'b0, 1'b1, 32'h1234, 32'h0, 1'b0};
    tbl[8] = '{LED, 1'b1, 1'b0, 32'h0, 32'h0000_A5A5, 1'b1};
    tbl[9] = '{32'h1000_000C, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    tbl[10] = '{32'h1000_0001, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    tbl[11] = '{DATA, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[12] = '{STAT, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h4, 1'b1};
    tbl[13] = '{STAT, 1'b1, 1'b0, 32'h0, 32'h4, 1'b1};
    bus.addr = STAT;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_we", uart_tx_we, 0);
    check("rst_tx_data", uart_tx_data, 0);
    check("rst_led", led_out, 0);
    check("rst_irq", irq, 0);
    check("rst_status", bus.rdata, 32'h4);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      bus.addr = tbl[i].addr;
      bus.rd = tbl[i].rd;
      bus.wr = tbl[i].wr;
      bus.wdata = tbl[i].wdata;
      #1;
      check($sformatf("tbl_rdata_%0d", i), bus.rdata, tbl[i].rdata);
      check($sformatf("tbl_hit_%0d", i), bus.hit, tbl[i].hit);
      tick();
    end
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    check("led_out", led_out, 16'hA5A5);
    check("irq_off", irq, 0);
    // TX burst of three back-to-back writes
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h41 + 8'(i));
      access(DATA, 1'b0, 1'b1, 32'hABCD_EF41 + i);
      if (i == 0) wcyc = cyc;
    end
    rd_chk("tx_cnt_burst", STAT, 32'h0002_0000);
    wait_obs(3, 100);
    if (obs_cyc.size() >= 3) begin
      check("tx_latency", obs_cyc[0], wcyc);
      check("tx_spacing", obs_cyc[1] - obs_cyc[0], 12);
    end
    obs_cyc.delete();
    cmp_tx("tx_burst");
    repeat (15) tick();
    rd_chk("tx_done_status", STAT, 32'h4);
    // TX overflow with the core held busy
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'h51 + 8'(i));
      access(DATA, 1'b0, 1'b1, 32'h51 + i);
    end
    rd_chk("tx_ovf_status", STAT, 32'h0004_0012);
    access(STAT, 1'b0, 1'b1, 32'h10);
    rd_chk("tx_ovf_clear", STAT, 32'h0004_0002);
    hold_busy = 1'b0;
    wait_obs(4, 150);
    cmp_tx("tx_ovf_byte");
    repeat (30) tick();
    check("tx_extra", obs_q.size(), 0);
    // Reset in the middle of a transmission
    exp_q.push_back(8'h61);
    access(DATA, 1'b0, 1'b1, 32'h61);
    access(DATA, 1'b0, 1'b1, 32'h62);
    repeat (3) tick();
    rst = 1'b0;
    bus.addr = STAT;
    #1;
    check("mid_rst_we", uart_tx_we, 0);
    check("mid_rst_data", uart_tx_data, 0);
    check("mid_rst_led", led_out, 0);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_status", bus.rdata, 32'h4);
    tick();
    rst = 1'b1;
    repeat (40) tick();
    check("mid_rst_count", obs_q.size(), 1);
    cmp_tx("mid_rst_byte");
    obs_cyc.delete();
    // RX overrun: five bytes into a four-entry FIFO
    base = re_cnt;
    for (int i = 1; i <= 5; i++) rx_src.push_back(8'(i));
    for (int k = 0; k < 100 && (rx_src.size() > 0 || uart_rx_valid); k++) tick();
    repeat (3) tick();
    check("rx_re_count", re_cnt - base, 5);
    check("rx_re_gap", re_b2b, 0);
    rd_chk("rx_ovr_status", STAT, 32'h0000_040D);
    access(STAT, 1'b0, 1'b1, 32'h08);
    rd_chk("rx_ovr_clear", STAT, 32'h0000_0405);
    // Pop and push on the same edge with the RX FIFO full
    rx_src.push_back(8'h06);
    for (int k = 0; k < 10 && !uart_rx_valid; k++) @(negedge clk);
    check("rx_valid_wait", uart_rx_valid, 1);
    check("rx_re_conc", uart_rx_re, 1);
    bus.addr = DATA;
    bus.rd = 1'b1;
    #1;
    check("rx_conc_data", bus.rdata, 32'h01);
    tick();
    bus.rd = 1'b0;
    rd_chk("rx_conc_status", STAT, 32'h0000_0405);
    rd_chk("rx_data_2", DATA, 32'h02);
    rd_chk("rx_data_3", DATA, 32'h03);
    rd_chk("rx_data_4", DATA, 32'h04);
    rd_chk("rx_data_6", DATA, 32'h06);
    rd_chk("rx_data_empty", DATA, 32'h0);
    rd_chk("rx_drained", STAT, 32'h4);
    // IRQ timing around one received byte
    access(CTRL, 1'b0, 1'b1, 32'h1);
    tick();
    check("irq_idle", irq, 0);
    rx_src.push_back(8'h5A);
    for (int k = 0; k < 10 && !uart_rx_re; k++) @(negedge clk);
    check("irq_re_wait", uart_rx_re, 1);
    cr = cyc;
    @(negedge clk);
    check("irq_cyc", cyc, cr + 1);
    check("irq_lag", irq, 0);
    bus.addr = STAT;
    #1;
    check("irq_nempty", bus.rdata, 32'h0000_0105);
    @(negedge clk);
    check("irq_rise", irq, 1);
    bus.addr = DATA;
    bus.rd = 1'b1;
    #1;
    check("irq_data", bus.rdata, 32'h5A);
    @(negedge clk);
    bus.rd = 1'b0;
    check("irq_hold", irq, 1);
    @(negedge clk);
    check("irq_fall", irq, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
